mem_arbiter: RTL and testbench

- Single-CPU memory controller that shares one wait-stated RAM port between the icache fill path (iREN/iaddr) and the dcache fill/writeback path (dREN/dWEN/daddr/dstore).
- Sits between the cache block's ccif signals and the RAM model.
- Grants one requester at a time, holds the grant until the RAM reports completion, and returns per-requester wait/load.
- Dcache has priority, with a bounded-starvation guarantee for the icache.

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one wait-stated RAM port between the icache fill path and the dcache
// fill/writeback path. Dcache has priority, but a pending icache request wins
// after STARVE_LIMIT consecutive dcache completions.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        ramerr,
    output logic [1:0]  fsm_state,
    output logic [3:0]  streak
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    state_t state;
    logic   d_req;
    logic   ram_done;
    logic   ram_fail;
    logic   starve;

    assign d_req     = dREN | dWEN;
    assign ram_done  = (ramstate == RAM_ACCESS);
    assign ram_fail  = (ramstate == RAM_ERROR);
    assign starve    = iREN && (streak >= 4'(STARVE_LIMIT));
    assign fsm_state = state;

    // Dropping the request before ACCESS aborts the grant without touching streak.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            streak <= 4'd0;
            ramerr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req && !starve) begin
                        state <= DGNT;
                    end else if (iREN) begin
                        state <= IGNT;
                    end
                end
                DGNT: begin
                    if (!d_req) begin
                        state <= IDLE;
                    end else if (ram_done) begin
                        state <= IDLE;
                        if (streak != 4'd15) begin
                            streak <= streak + 4'd1;
                        end
                    end else if (ram_fail) begin
                        ramerr <= 1'b1;
                    end
                end
                IGNT: begin
                    if (!iREN) begin
                        state <= IDLE;
                    end else if (ram_done) begin
                        state  <= IDLE;
                        streak <= 4'd0;
                    end else if (ram_fail) begin
                        ramerr <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM port, wait and load follow the current grant and live requester inputs.
    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = 32'd0;
        dload    = 32'd0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        if (!RST) begin
            case (state)
                DGNT: begin
                    if (d_req) begin
                        ramREN   = dREN;
                        ramWEN   = dWEN;
                        ramaddr  = daddr;
                        ramstore = dstore;
                        if (ram_done) begin
                            dwait = 1'b0;
                            dload = ramload;
                        end
                    end
                end
                IGNT: begin
                    if (iREN) begin
                        ramREN  = 1'b1;
                        ramaddr = iaddr;
                        if (ram_done) begin
                            iwait = 1'b0;
                            iload = ramload;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, icache read, priority, starvation
// bound, RAM error retry and request abort.
module tb_mem_arbiter;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_IGNT = 2'd1;
    localparam logic [1:0] S_DGNT = 2'd2;
    localparam logic [1:0] R_FREE   = 2'd0;
    localparam logic [1:0] R_BUSY   = 2'd1;
    localparam logic [1:0] R_ACCESS = 2'd2;
    localparam logic [1:0] R_ERROR  = 2'd3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, ramerr;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic [1:0]  fsm_state;
    logic [3:0]  streak;

    int checks = 0;
    int passes = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .ramerr(ramerr),
        .fsm_state(fsm_state), .streak(streak)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 32'h12345678; ramstate = R_FREE;
        #2;
        checks++;
        if ({ramREN, ramWEN, iwait, dwait, ramerr, fsm_state, streak} !== {4'b0011, 1'b0, S_IDLE, 4'd0})
            $display("FAIL reset_ctrl: got %b expected %b",
                     {ramREN, ramWEN, iwait, dwait, ramerr, fsm_state, streak}, {4'b0011, 1'b0, S_IDLE, 4'd0});
        else passes++;
        checks++;
        if ({ramaddr, ramstore, iload, dload} !== 128'd0)
            $display("FAIL reset_data: got %h expected 0", {ramaddr, ramstore, iload, dload});
        else passes++;
        tick();
        RST = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_grant();
        dREN = 1; daddr = 32'h100; ramstate = R_BUSY;
        tick();
        tick();
        checks++;
        if ({fsm_state, ramREN, ramaddr} !== {S_DGNT, 1'b1, 32'h100})
            $display("FAIL busy_grant: got %h expected %h", {fsm_state, ramREN, ramaddr}, {S_DGNT, 1'b1, 32'h100});
        else passes++;
        RST = 1'b1;
        #1;
        checks++;
        if ({fsm_state, ramREN, dwait, ramaddr} !== {S_IDLE, 2'b01, 32'h0})
            $display("FAIL reset_mid_grant: got %h expected %h", {fsm_state, ramREN, dwait, ramaddr}, {S_IDLE, 2'b01, 32'h0});
        else passes++;
        tick();
        RST = 1'b0;
        #1;
        checks++;
        if ({fsm_state, ramREN} !== {S_IDLE, 1'b0})
            $display("FAIL post_reset_arb: got %b expected %b", {fsm_state, ramREN}, {S_IDLE, 1'b0});
        else passes++;
        tick();
        checks++;
        if ({fsm_state, ramREN, ramaddr} !== {S_DGNT, 1'b1, 32'h100})
            $display("FAIL post_reset_grant: got %h expected %h", {fsm_state, ramREN, ramaddr}, {S_DGNT, 1'b1, 32'h100});
        else passes++;
        dREN = 0;
        tick();
        ramstate = R_FREE;
    endtask

    task automatic test_icache_read();
        iREN = 1; iaddr = 32'h40; ramstate = R_FREE; ramload = 32'h0;
        #1;
        checks++;
        if ({fsm_state, ramREN, iwait} !== {S_IDLE, 2'b01})
            $display("FAIL i_arb_cycle: got %b expected %b", {fsm_state, ramREN, iwait}, {S_IDLE, 2'b01});
        else passes++;
        for (int c = 0; c < 3; c++) begin
            tick();
            ramstate = (c == 2) ? R_ACCESS : R_BUSY;
            ramload  = (c == 2) ? 32'h2402000A : 32'hFFFF0000;
            #1;
            checks++;
            if ({ramREN, ramWEN, ramaddr, iwait, dwait, iload} !==
                {2'b10, 32'h40, (c != 2), 1'b1, (c == 2) ? 32'h2402000A : 32'h0})
                $display("FAIL i_read_c%0d: got %h expected %h", c, {ramREN, ramWEN, ramaddr, iwait, dwait, iload},
                         {2'b10, 32'h40, (c != 2), 1'b1, (c == 2) ? 32'h2402000A : 32'h0});
            else passes++;
        end
        tick();
        iREN = 0;
        #1;
        checks++;
        if ({fsm_state, ramREN, iwait, iload, streak} !== {S_IDLE, 2'b01, 32'h0, 4'd0})
            $display("FAIL i_read_done: got %h expected %h", {fsm_state, ramREN, iwait, iload, streak}, {S_IDLE, 2'b01, 32'h0, 4'd0});
        else passes++;
        ramstate = R_FREE;
    endtask

    task automatic test_priority();
        dWEN = 1; daddr = 32'h80; dstore = 32'hDEADBEEF;
        iREN = 1; iaddr = 32'h44; ramstate = R_ACCESS; ramload = 32'hCAFE0001;
        tick();
        checks++;
        if ({fsm_state, ramREN, ramWEN, ramaddr, ramstore, dwait, iwait} !==
            {S_DGNT, 2'b01, 32'h80, 32'hDEADBEEF, 2'b01})
            $display("FAIL d_first: got %h expected %h", {fsm_state, ramREN, ramWEN, ramaddr, ramstore, dwait, iwait},
                     {S_DGNT, 2'b01, 32'h80, 32'hDEADBEEF, 2'b01});
        else passes++;
        tick();
        dWEN = 0;
        #1;
        checks++;
        if ({fsm_state, ramREN, ramWEN, iwait, streak} !== {S_IDLE, 3'b001, 4'd1})
            $display("FAIL bubble: got %b expected %b", {fsm_state, ramREN, ramWEN, iwait, streak}, {S_IDLE, 3'b001, 4'd1});
        else passes++;
        tick();
        checks++;
        if ({fsm_state, ramREN, ramWEN, ramaddr, ramstore, iwait, iload} !==
            {S_IGNT, 2'b10, 32'h44, 32'h0, 1'b0, 32'hCAFE0001})
            $display("FAIL i_second: got %h expected %h", {fsm_state, ramREN, ramWEN, ramaddr, ramstore, iwait, iload},
                     {S_IGNT, 2'b10, 32'h44, 32'h0, 1'b0, 32'hCAFE0001});
        else passes++;
        tick();
        iREN = 0; ramstate = R_FREE;
        #1;
        checks++;
        if ({fsm_state, streak} !== {S_IDLE, 4'd0})
            $display("FAIL prio_end: got %b expected %b", {fsm_state, streak}, {S_IDLE, 4'd0});
        else passes++;
    endtask

    task automatic test_starvation();
        logic exp_d, exp_i;
        dREN = 1; iREN = 1; daddr = 32'h300; iaddr = 32'h500; ramstate = R_ACCESS;
        for (int c = 0; c < 12; c++) begin
            ramload = 32'h1000 + 32'(c);
            #1;
            exp_d = (c == 1) || (c == 3) || (c == 5) || (c == 7) || (c == 11);
            exp_i = (c == 9);
            checks++;
            if ({dwait, iwait, dload, iload} !==
                {!exp_d, !exp_i, exp_d ? 32'h1000 + 32'(c) : 32'h0, exp_i ? 32'h1000 + 32'(c) : 32'h0})
                $display("FAIL starve_c%0d: got %h expected %h", c, {dwait, iwait, dload, iload},
                         {!exp_d, !exp_i, exp_d ? 32'h1000 + 32'(c) : 32'h0, exp_i ? 32'h1000 + 32'(c) : 32'h0});
            else passes++;
            if (c == 8) begin
                checks++;
                if (streak !== 4'd4) $display("FAIL streak_at_limit: got %0d expected 4", streak);
                else passes++;
            end
            tick();
        end
        dREN = 0; iREN = 0; ramstate = R_FREE;
        #1;
        checks++;
        if ({fsm_state, streak} !== {S_IDLE, 4'd1})
            $display("FAIL starve_end: got %b expected %b", {fsm_state, streak}, {S_IDLE, 4'd1});
        else passes++;
    endtask

    task automatic test_error();
        dREN = 1; daddr = 32'h200; ramstate = R_ERROR; ramload = 32'h55;
        tick();
        checks++;
        if ({fsm_state, ramREN, dwait, dload, ramerr} !== {S_DGNT, 2'b11, 32'h0, 1'b0})
            $display("FAIL err_first: got %h expected %h", {fsm_state, ramREN, dwait, dload, ramerr}, {S_DGNT, 2'b11, 32'h0, 1'b0});
        else passes++;
        tick();
        checks++;
        if ({fsm_state, ramREN, dwait, ramerr} !== {S_DGNT, 3'b111})
            $display("FAIL err_second: got %b expected %b", {fsm_state, ramREN, dwait, ramerr}, {S_DGNT, 3'b111});
        else passes++;
        tick();
        ramstate = R_ACCESS;
        #1;
        checks++;
        if ({dwait, dload, ramerr} !== {1'b0, 32'h55, 1'b1})
            $display("FAIL err_retry_done: got %h expected %h", {dwait, dload, ramerr}, {1'b0, 32'h55, 1'b1});
        else passes++;
        tick();
        dREN = 0; ramstate = R_FREE;
        tick();
        tick();
        checks++;
        if ({fsm_state, ramerr} !== {S_IDLE, 1'b1})
            $display("FAIL err_sticky: got %b expected %b", {fsm_state, ramerr}, {S_IDLE, 1'b1});
        else passes++;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        checks++;
        if ({ramerr, streak} !== {1'b0, 4'd0})
            $display("FAIL err_cleared: got %b expected %b", {ramerr, streak}, {1'b0, 4'd0});
        else passes++;
    endtask

    task automatic test_abort();
        dREN = 1; daddr = 32'h600; ramstate = R_ACCESS; ramload = 32'h77;
        tick();
        tick();
        ramstate = R_BUSY;
        #1;
        checks++;
        if ({fsm_state, streak} !== {S_IDLE, 4'd1})
            $display("FAIL abort_setup: got %b expected %b", {fsm_state, streak}, {S_IDLE, 4'd1});
        else passes++;
        tick();
        checks++;
        if ({fsm_state, ramREN, dwait} !== {S_DGNT, 2'b11})
            $display("FAIL abort_grant: got %b expected %b", {fsm_state, ramREN, dwait}, {S_DGNT, 2'b11});
        else passes++;
        tick();
        dREN = 0;
        #1;
        checks++;
        if ({fsm_state, ramREN, ramWEN, dwait, dload} !== {S_DGNT, 3'b001, 32'h0})
            $display("FAIL abort_drop: got %h expected %h", {fsm_state, ramREN, ramWEN, dwait, dload}, {S_DGNT, 3'b001, 32'h0});
        else passes++;
        ramstate = R_ACCESS;
        #1;
        checks++;
        if ({ramREN, dwait} !== 2'b01)
            $display("FAIL abort_no_done: got %b expected 01", {ramREN, dwait});
        else passes++;
        tick();
        checks++;
        if ({fsm_state, streak, dwait} !== {S_IDLE, 4'd1, 1'b1})
            $display("FAIL abort_end: got %b expected %b", {fsm_state, streak, dwait}, {S_IDLE, 4'd1, 1'b1});
        else passes++;
        ramstate = R_FREE;
    endtask

    initial begin
        test_reset();
        test_reset_mid_grant();
        test_icache_read();
        test_priority();
        test_starvation();
        test_error();
        test_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
